// File: rtl/operand_loader.sv
// Two-operand capture front end: loads A then B from a shared bus on load
// rising edges and drives the downstream operand/display mux select.
module operand_loader #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic         view,
  input  logic [N-1:0] din,
  output logic [N-1:0] op_a,
  output logic [N-1:0] op_b,
  output logic         sel,
  output logic         valid,
  output logic [1:0]   phase
);

  typedef enum logic [1:0] {
    GET_A   = 2'b00,
    GET_B   = 2'b01,
    READY   = 2'b10,
    ILLEGAL = 2'b11
  } phase_t;

  phase_t state;
  logic   load_q;
  logic   ld;

  // load_q resets high so a load held through reset release is not an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) load_q <= 1'b1;
    else     load_q <= load;
  end

  assign ld    = load & ~load_q;
  assign phase = state;

  // Capture FSM; clear beats ld, and every output is a register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= GET_A;
      op_a  <= '0;
      op_b  <= '0;
      sel   <= 1'b0;
      valid <= 1'b0;
    end else if (clear) begin
      state <= GET_A;
      op_a  <= '0;
      op_b  <= '0;
      sel   <= 1'b0;
      valid <= 1'b0;
    end else begin
      case (state)
        GET_A: begin
          if (ld) begin
            op_a  <= din;
            state <= GET_B;
            sel   <= 1'b1;
          end else begin
            sel <= 1'b0;
          end
        end
        GET_B: begin
          if (ld) begin
            op_b  <= din;
            valid <= 1'b1;
            state <= READY;
            sel   <= view;
          end else begin
            sel <= 1'b1;
          end
        end
        READY: begin
          if (ld) begin
            op_a  <= din;
            valid <= 1'b0;
            state <= GET_B;
            sel   <= 1'b1;
          end else begin
            sel <= view;
          end
        end
        default: begin
          // unreachable encoding: recover with the clear values, no capture
          state <= GET_A;
          op_a  <= '0;
          op_b  <= '0;
          sel   <= 1'b0;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_loader.sv
// Scoreboard bench for operand_loader: a driver pushes model expectations,
// a monitor pops and compares them after every rising edge.
module tb_operand_loader;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic         clear;
  logic         view;
  logic [N-1:0] din;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic         sel;
  logic         valid;
  logic [1:0]   phase;

  operand_loader #(.N(N)) dut (
    .clk(clk), .rst(rst), .load(load), .clear(clear), .view(view),
    .din(din), .op_a(op_a), .op_b(op_b), .sel(sel), .valid(valid),
    .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         s;
    logic         v;
    logic [1:0]   p;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // reference model state: which operand is next (0=A,1=B,2=pair complete)
  int           m_next;
  logic [N-1:0] m_a, m_b;
  logic         m_sel, m_valid, m_prev;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_next = 0; m_a = '0; m_b = '0; m_sel = 1'b0; m_valid = 1'b0; m_prev = 1'b1;
  endtask

  task automatic model_step(input logic l, input logic c, input logic v, input logic [N-1:0] d);
    logic edge_seen;
    edge_seen = l && !m_prev;
    m_prev = l;
    if (c) begin
      m_next = 0; m_a = '0; m_b = '0; m_sel = 1'b0; m_valid = 1'b0;
    end else if (m_next == 0) begin
      if (edge_seen) begin m_a = d; m_next = 1; m_sel = 1'b1; end
      else m_sel = 1'b0;
    end else if (m_next == 1) begin
      if (edge_seen) begin m_b = d; m_valid = 1'b1; m_next = 2; m_sel = v; end
      else m_sel = 1'b1;
    end else begin
      if (edge_seen) begin m_a = d; m_valid = 1'b0; m_next = 1; m_sel = 1'b1; end
      else m_sel = v;
    end
  endtask

  // one clock of stimulus; expectation is for the outputs after the next rising edge
  task automatic cyc(input logic l, input logic c, input logic v, input logic [N-1:0] d);
    exp_t e;
    @(negedge clk);
    load = l; clear = c; view = v; din = d;
    model_step(l, c, v, d);
    e.a = m_a; e.b = m_b; e.s = m_sel; e.v = m_valid;
    e.p = (m_next == 0) ? 2'b00 : (m_next == 1) ? 2'b01 : 2'b10;
    sb.push_back(e);
  endtask

  // monitor: outputs are presented every cycle, compare just after each edge
  always @(posedge clk) begin
    #1;
    if (!rst && sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("op_a",  32'(op_a),  32'(e.a));
      chk("op_b",  32'(op_b),  32'(e.b));
      chk("sel",   32'(sel),   32'(e.s));
      chk("valid", 32'(valid), 32'(e.v));
      chk("phase", 32'(phase), 32'(e.p));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_op_a"},  32'(op_a),  32'd0);
    chk({tag, "_op_b"},  32'(op_b),  32'd0);
    chk({tag, "_sel"},   32'(sel),   32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_phase"}, 32'(phase), 32'd0);
  endtask

  initial begin
    rst = 1'b1; load = 1'b1; clear = 1'b0; view = 1'b0; din = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // load held high through reset release must not capture
    cyc(1, 0, 0, 8'h11);
    cyc(0, 0, 0, 8'h12);

    // reset then a pair
    cyc(1, 0, 0, 8'h3C);
    cyc(0, 0, 0, 8'h00);
    cyc(1, 0, 1, 8'hA5);
    cyc(0, 0, 0, 8'h00);

    // held load in GET_A: one capture of the first-cycle din
    cyc(0, 1, 0, 8'h00);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 8'(8'h40 + i));
    cyc(0, 0, 0, 8'h00);

    // clear with a simultaneous load edge in GET_B
    cyc(1, 1, 0, 8'hFF);
    cyc(0, 0, 0, 8'h00);

    // build 11/22 pair, then restart from READY with 77 (1,0,1 spacing)
    cyc(1, 0, 0, 8'h11);
    cyc(0, 0, 0, 8'h00);
    cyc(1, 0, 0, 8'h22);
    cyc(0, 0, 0, 8'h00);
    cyc(1, 0, 0, 8'h77);
    cyc(0, 0, 0, 8'h00);

    // complete the pair, toggle view in READY
    cyc(1, 0, 0, 8'h88);
    cyc(0, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'h00);
    cyc(0, 0, 0, 8'h00);

    // asynchronous reset mid-cycle, checked before the next rising edge
    @(negedge clk);
    #1 rst = 1'b1;
    #1 chk_zero("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // randomized traffic
    for (int i = 0; i < 600; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
          1'($urandom_range(0, 1)), 8'($urandom));

    @(posedge clk);
    #3;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
